// File: rtl/slave_resp_mux.sv
// Registered slave read-return mux: latches the selected slave per request, waits for its
// ready, and returns a registered data word plus a one-cycle ready strobe and error code.
module slave_resp_mux #(
    parameter int N_SLAVES = 8,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_req,
    input  logic [N_SLAVES-1:0]        s_cs,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES*DATA_W-1:0] s_rd_data,
    output logic [DATA_W-1:0]          m_rd_data,
    output logic                       m_ready,
    output logic [1:0]                 m_err,
    output logic                       busy
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    // Expiry fires at TIMEOUT-1, so the counter never needs to wrap.
    localparam bit              WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] sel_idx;

    logic [0:0]        nxt_state;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [IDX_W-1:0]  nxt_idx;
    logic              nxt_ready;
    logic [1:0]        nxt_err;
    logic [DATA_W-1:0] nxt_data;

    logic              cs_none;
    logic              cs_multi;
    logic [IDX_W-1:0]  cs_idx;
    logic [IDX_W-1:0]  act_idx;
    logic              act_ready;
    logic [DATA_W-1:0] act_data;

    // Chip-select classification: a set bit surviving x & (x-1) means two or more are set.
    assign cs_none  = ~|s_cs;
    assign cs_multi = |(s_cs & (s_cs - N_SLAVES'(1)));

    always_comb begin
        cs_idx = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_cs[i]) cs_idx = IDX_W'(i);
        end
    end

    // In IDLE the fast path looks at the slave being selected right now;
    // in WAIT only the latched slave is observed.
    assign act_idx = (state == ST_IDLE) ? cs_idx : sel_idx;

    always_comb begin
        act_ready = 1'b0;
        act_data  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (act_idx == IDX_W'(i)) begin
                act_ready = s_ready[i];
                act_data  = s_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = sel_idx;
        nxt_ready = 1'b0;
        nxt_err   = m_err;
        nxt_data  = m_rd_data;

        case (state)
            ST_IDLE: begin
                if (m_req && !cs_none) begin
                    if (cs_multi) begin
                        nxt_ready = 1'b1;
                        nxt_err   = ERR_ILLEGAL;
                        nxt_data  = '0;
                    end else begin
                        nxt_idx = cs_idx;
                        if (act_ready) begin
                            nxt_ready = 1'b1;
                            nxt_err   = ERR_OK;
                            nxt_data  = act_data;
                        end else begin
                            nxt_state = ST_WAIT;
                            nxt_cnt   = '0;
                        end
                    end
                end
            end

            ST_WAIT: begin
                // Ready wins over a simultaneous watchdog expiry.
                if (act_ready) begin
                    nxt_ready = 1'b1;
                    nxt_err   = ERR_OK;
                    nxt_data  = act_data;
                    nxt_state = ST_IDLE;
                end else if (WDOG_EN && (cnt == CNT_LAST)) begin
                    nxt_ready = 1'b1;
                    nxt_err   = ERR_TIMEOUT;
                    nxt_data  = '0;
                    nxt_state = ST_IDLE;
                end else if (WDOG_EN) begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end

            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sel_idx   <= '0;
            m_ready   <= 1'b0;
            m_err     <= ERR_OK;
            m_rd_data <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            sel_idx   <= nxt_idx;
            m_ready   <= nxt_ready;
            m_err     <= nxt_err;
            m_rd_data <= nxt_data;
            busy      <= (nxt_state == ST_WAIT);
        end
    end

endmodule

// File: tb/tb_slave_resp_mux.sv
// Directed bench for slave_resp_mux: stimulus pushes expected responses into queues,
// per-instance monitors pop and compare whenever m_ready is seen.
module tb_slave_resp_mux;

    localparam int N  = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    err;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: default parameters.
    logic            a_req;
    logic [N-1:0]    a_cs, a_rdy;
    logic [N*DW-1:0] a_data;
    logic [DW-1:0]   a_rd;
    logic            a_mready;
    logic [1:0]      a_err;
    logic            a_busy;

    // Instance B: short watchdog.
    logic            b_req;
    logic [N-1:0]    b_cs, b_rdy;
    logic [N*DW-1:0] b_data;
    logic [DW-1:0]   b_rd;
    logic            b_mready;
    logic [1:0]      b_err;
    logic            b_busy;

    slave_resp_mux #(.N_SLAVES(N), .DATA_W(DW), .TIMEOUT(255), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .m_req(a_req), .s_cs(a_cs), .s_ready(a_rdy),
        .s_rd_data(a_data), .m_rd_data(a_rd), .m_ready(a_mready), .m_err(a_err), .busy(a_busy)
    );

    slave_resp_mux #(.N_SLAVES(N), .DATA_W(DW), .TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .m_req(b_req), .s_cs(b_cs), .s_ready(b_rdy),
        .s_rd_data(b_data), .m_rd_data(b_rd), .m_ready(b_mready), .m_err(b_err), .busy(b_busy)
    );

    resp_t exp_a[$];
    resp_t exp_b[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (a_mready === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_unexpected_ready: got response data %h err %b, required no response", a_rd, a_err);
            end else begin
                e = exp_a.pop_front();
                check("a_rd_data", a_rd, e.data);
                check("a_err", DW'(a_err), DW'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        resp_t e;
        if (b_mready === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected_ready: got response data %h err %b, required no response", b_rd, b_err);
            end else begin
                e = exp_b.pop_front();
                check("b_rd_data", b_rd, e.data);
                check("b_err", DW'(b_err), DW'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0;
        a_req = 1'b0; a_cs = '0; a_rdy = '0;
        b_req = 1'b0; b_cs = '0; b_rdy = '0;
        for (int i = 0; i < N; i++) begin
            a_data[i*DW +: DW] = 32'h1000_0000 + i;
            b_data[i*DW +: DW] = 32'h2000_0000 + i;
        end

        // Reset state
        tick(); tick();
        check("reset_m_ready", DW'(a_mready), 0);
        check("reset_m_err", DW'(a_err), 0);
        check("reset_m_rd_data", a_rd, 0);
        check("reset_busy", DW'(a_busy), 0);
        reset = 1'b1;
        tick();

        // 1. Fast path on slave 2
        a_data[2*DW +: DW] = 32'hDEAD_BEEF;
        a_req = 1'b1; a_cs = 8'b0000_0100; a_rdy = 8'b0000_0100;
        exp_a.push_back('{data: 32'hDEAD_BEEF, err: 2'b00});
        tick();
        a_req = 1'b0; a_cs = '0; a_rdy = '0;
        check("fast_busy", DW'(a_busy), 0);
        check("fast_m_ready", DW'(a_mready), 1);
        tick(); tick();

        // 2. Wait path on slave 7, ready in the fifth WAIT cycle
        a_req = 1'b1; a_cs = 8'b1000_0000;
        tick();
        a_req = 1'b0; a_cs = 8'b0000_0001;
        for (int i = 0; i < 4; i++) begin
            check("wait_busy", DW'(a_busy), 1);
            tick();
        end
        a_data[7*DW +: DW] = 32'h1234_5678;
        a_rdy = 8'b1000_0000;
        exp_a.push_back('{data: 32'h1234_5678, err: 2'b00});
        check("wait_busy_last", DW'(a_busy), 1);
        tick();
        a_rdy = '0; a_cs = '0;
        check("wait_done_busy", DW'(a_busy), 0);
        tick(); tick();

        // 4. Illegal select, then an empty select that must be dropped
        a_req = 1'b1; a_cs = 8'b0001_0010; a_rdy = 8'b0001_0010;
        exp_a.push_back('{data: 32'h0, err: 2'b10});
        tick();
        a_req = 1'b1; a_cs = '0; a_rdy = '0;
        tick();
        a_req = 1'b0;
        repeat (10) tick();
        check("drop_busy", DW'(a_busy), 0);

        // 5. Isolation: foreign ready and extra m_req ignored while waiting on slave 3
        a_req = 1'b1; a_cs = 8'b0000_1000;
        tick();
        a_req = 1'b0; a_cs = '0;
        tick();
        a_data[5*DW +: DW] = 32'hFFFF_FFFF;
        a_rdy = 8'b0010_0000; a_req = 1'b1; a_cs = 8'b0010_0000;
        tick();
        a_rdy = '0; a_req = 1'b0; a_cs = '0;
        tick();
        check("iso_busy", DW'(a_busy), 1);
        a_data[3*DW +: DW] = 32'hA5A5_A5A5;
        a_rdy = 8'b0000_1000;
        exp_a.push_back('{data: 32'hA5A5_A5A5, err: 2'b00});
        tick();
        a_rdy = '0;
        tick(); tick();

        // 3. Watchdog on instance B: expiry after four WAIT cycles
        b_req = 1'b1; b_cs = 8'b0000_0010;
        exp_b.push_back('{data: 32'h0, err: 2'b01});
        tick();
        b_req = 1'b0; b_cs = '0;
        for (int i = 0; i < 4; i++) begin
            check("to_busy", DW'(b_busy), 1);
            tick();
        end
        check("to_done_busy", DW'(b_busy), 0);
        tick(); tick();

        // 3b. Ready in the fourth WAIT cycle beats the expiry
        b_req = 1'b1; b_cs = 8'b0000_0010;
        tick();
        b_req = 1'b0; b_cs = '0;
        tick(); tick(); tick();
        check("to_race_busy", DW'(b_busy), 1);
        b_data[1*DW +: DW] = 32'h0BAD_F00D;
        b_rdy = 8'b0000_0010;
        exp_b.push_back('{data: 32'h0BAD_F00D, err: 2'b00});
        tick();
        b_rdy = '0;
        tick(); tick();

        // 6. Reset mid-transaction on slave 0 aborts silently
        a_req = 1'b1; a_cs = 8'b0000_0001;
        tick();
        a_req = 1'b0; a_cs = '0;
        check("pre_reset_busy", DW'(a_busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        a_rdy = 8'b0000_0001;
        repeat (5) tick();
        check("abort_busy", DW'(a_busy), 0);
        check("abort_m_rd_data", a_rd, 0);
        check("abort_m_err", DW'(a_err), 0);
        check("abort_m_ready", DW'(a_mready), 0);
        a_rdy = '0;
        tick(); tick();

        check("a_queue_drained", DW'(exp_a.size()), 0);
        check("b_queue_drained", DW'(exp_b.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_resp_mux.md
Name: slave_resp_mux

Overview:
- Parametrised, registered successor to the combinational slave read-return mux.
- Sits between the bus address decoder and the bus master.
- Per transaction, it latches which slave was selected, waits for that slave's ready, then returns a registered read-data word and ready pulse to the master.
- It adds a timeout watchdog and illegal-select detection, reported through an error code.

Parameters:
- N_SLAVES, 8, number of slave ports (2..32).
- DATA_W, 32, read-data width in bits.
- TIMEOUT, 255, maximum WAIT cycles before an error response; 0 disables the watchdog.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset, in, 1, synchronous active-low reset.
- m_req, in, 1, single-cycle transaction start strobe from the master.
- s_cs, in, N_SLAVES, decoded chip selects; sampled only when m_req=1 in IDLE.
- s_ready, in, N_SLAVES, per-slave ready.
- s_rd_data, in, N_SLAVES*DATA_W, flattened slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- m_rd_data, out, DATA_W, registered read data returned to the master.
- m_ready, out, 1, one-cycle response strobe.
- m_err, out, 2, error code valid with m_ready: 00 OK, 01 timeout, 10 illegal select.
- busy, out, 1, high while in WAIT.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state goes to IDLE; counter and latched index clear to 0.
  - m_rd_data=0, m_ready=0, m_err=00, busy=0.
  - Reset overrides every other event.
  - A transaction in flight when reset is applied is aborted silently; no response is ever issued for it.
- All outputs are registered.
- m_ready is high for exactly one cycle per accepted request and is 0 in every other cycle.
- m_rd_data and m_err hold their last values between responses.
- State IDLE:
  - m_req=0: no action.
  - m_req=1 and s_cs all zero: request dropped; no response, stay in IDLE.
  - m_req=1 and s_cs has two or more bits set: next cycle m_ready=1, m_err=10, m_rd_data=0; stay in IDLE.
  - m_req=1 and s_cs one-hot at index k: latch k.
    - If s_ready[k]=1 in the same cycle: next cycle m_ready=1, m_err=00, m_rd_data = slave k's data sampled in the request cycle; stay in IDLE. This is the minimum latency of 1 cycle.
    - Otherwise: go to WAIT, counter=0, busy=1 from the next cycle.
- State WAIT:
  - s_cs and m_req are ignored; a new m_req while busy is dropped with no response.
  - s_ready[k]=1: next cycle m_ready=1, m_err=00, m_rd_data = slave k's data sampled that cycle; go to IDLE; busy=0.
  - Else, if TIMEOUT≠0 and counter==TIMEOUT-1: next cycle m_ready=1, m_err=01, m_rd_data=0; go to IDLE.
  - Otherwise counter increments by 1.
  - Ready arriving in the same cycle as timeout expiry is a normal response; ready takes precedence.
  - TIMEOUT=0: WAIT lasts indefinitely until ready.
- Ready or data from non-selected slaves never affects the outputs.
- A back-to-back m_req is accepted in the same cycle that m_ready is high, because the block is back in IDLE by then.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps, because expiry occurs at TIMEOUT-1.

Test Plan:
1. Fast path: reset low 2 cycles then high; m_req=1, s_cs=8'b0000_0100, s_ready[2]=1, slave 2 data=0xDEADBEEF -> next cycle m_ready=1, m_err=00, m_rd_data=0xDEADBEEF, busy=0.
2. Wait path: m_req with s_cs=8'b1000_0000; s_ready[7] rises 5 cycles later with data 0x12345678 -> busy=1 for 5 cycles, then m_ready=1, m_rd_data=0x12345678, m_err=00.
3. Timeout: TIMEOUT=4; select slave 1, ready never asserted -> 4 WAIT cycles, then m_ready=1, m_err=01, m_rd_data=0. Repeat with ready asserted exactly on the 4th WAIT cycle -> m_err=00 with that slave's data.
4. Illegal select: m_req with s_cs=8'b0001_0010 -> next cycle m_ready=1, m_err=10, m_rd_data=0. m_req with s_cs=0 -> no m_ready for 10 cycles.
5. Isolation and drops: in WAIT on slave 3, pulse s_ready[5] with data 0xFFFFFFFF and issue an extra m_req -> no response. Then s_ready[3]=1 with data 0xA5A5A5A5 -> single m_ready with 0xA5A5A5A5.
6. Reset mid-transaction: enter WAIT on slave 0, assert reset for 1 cycle, then release and hold s_ready[0]=1 -> m_ready stays 0, busy=0, m_rd_data=0, m_err=00.
